decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter RNONE, default 4'hF, register-ID code meaning "no register".
REQ-002 Parameter RSP, default 4'h4, stack-pointer register ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall_d  input  1  hold D pipeline register contents this edge.
REQ-006 bubble_d  input  1  load NOP bubble into D pipeline register this edge.
REQ-007 f_icode, f_ifun, f_rA, f_rB  input  4 each  fields from fetch stage.
REQ-008 f_valC, f_valP  input  64 each  constant and next-PC from fetch stage.
REQ-009 f_halt  input  1  fetch-stage halt flag.
REQ-010 w_dstE, w_dstM  input  4 each  writeback destination IDs (RNONE = no write).
REQ-011 w_valE, w_valM  input  64 each  writeback data.
REQ-012 d_icode, d_ifun  output  4 each  registered icode/ifun.
REQ-013 d_valC, d_valP  output  64 each  registered valC/valP.
REQ-014 d_halt  output  1  registered halt flag.
REQ-015 d_ins_err  output  1  registered icode > 4'hB.
REQ-016 d_srcA, d_srcB, d_dstE, d_dstM  output  4 each  decoded register IDs.
REQ-017 d_valA, d_valB  output  64 each  operand values.

Function
REQ-018 D register (icode, ifun, rA, rB, valC, valP, halt) SHALL update every rising edge; priority rst_n low > stall_d > bubble_d > load from f_*.
REQ-019 Bubble/reset value: icode 4'h1 (NOP), ifun 0, rA=rB=RNONE, valC=valP=0, halt 0.
REQ-020 stall_d and bubble_d both high: stall wins, register holds.
REQ-021 d_icode, d_ifun, d_valC, d_valP, d_halt SHALL be the D register fields; d_ins_err = (D.icode > 4'hB); one-cycle latency from f_* to these outputs.
REQ-022 d_srcA: rA for icode 2,4,6,A; RSP for 9,B; else RNONE.
REQ-023 d_srcB: rB for icode 4,5,6; RSP for 8,9,A,B; else RNONE.
REQ-024 d_dstE: rB for icode 2,3,6; RSP for 8,9,A,B; else RNONE (cmov condition resolved downstream).
REQ-025 d_dstM: rA for icode 5,B; else RNONE.
REQ-026 Register file: 15 x 64-bit registers, IDs 0..14; ID 15 never stored.
REQ-027 Write on rising edge when rst_n high: w_dstE != RNONE writes w_valE; w_dstM != RNONE writes w_valM; same ID on both: w_valM wins.
REQ-028 Reads combinational; srcX = RNONE returns 0.
REQ-029 Same-cycle bypass for each read port: srcX != RNONE and srcX == w_dstM -> w_valM; else srcX == w_dstE -> w_valE; else stored value.
REQ-030 d_valA = d_valP for icode 7 (JXX) and 8 (CALL); else read-port-A value.
REQ-031 d_valB = read-port-B value.
REQ-032 No arithmetic other than comparison; all 64-bit paths pass unmodified.

Reset
REQ-033 rst_n low at a rising edge: D register loads bubble value, all 15 registers clear to 0, writeback writes that edge ignored.
REQ-034 After reset, outputs: d_icode 1, d_ifun 0, d_valC 0, d_valP 0, d_halt 0, d_ins_err 0, all src/dst = RNONE, d_valA = d_valB = 0.
REQ-035 Reset mid-stream discards the held instruction; no partial register write survives.

Verification
REQ-036 Reset, then f_icode=3, f_rA=F, f_rB=2, f_valC=0xAA, f_valP=12 -> next cycle d_icode 3, d_dstE 2, d_srcA=d_srcB=F, d_valC 0xAA, d_valP 12.
REQ-037 w_dstE=2, w_valE=0xAA one cycle; then OPQ rA=2 rB=4 -> d_srcA 2, d_valA 0xAA, d_valB 0, d_dstE 4.
REQ-038 D holds OPQ rA=3 rB=5, same cycle w_dstM=3, w_valM=0x55 and w_dstE=5, w_valE=0x77 -> d_valA 0x55, d_valB 0x77 (bypass); w_dstE=w_dstM=6 with valE 1, valM 2 -> reg6 reads 2.
REQ-039 Load JXX valP=39 with reg RSP=0x100 -> d_valA 39; POPQ rA=3 -> d_srcA 4, d_srcB 4, d_dstE 4, d_dstM 3, d_valA 0x100.
REQ-040 stall_d high two cycles with changing f_* -> D outputs unchanged; stall_d+bubble_d together -> hold; bubble_d alone -> NOP outputs; f_icode=4'hC -> d_ins_err 1.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-to-decode, writeback-to-decode and decode-output bundle for decode_stage.
// The master side (fetch/writeback/testbench) drives f_* and w_*; the slave (decode) drives d_*.
interface decode_stage_if;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        f_halt;

    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic [63:0] w_valE;
    logic [63:0] w_valM;

    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [63:0] d_valC;
    logic [63:0] d_valP;
    logic        d_halt;
    logic        d_ins_err;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [63:0] d_valA;
    logic [63:0] d_valB;

    modport master (
        output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_halt,
        output w_dstE, w_dstM, w_valE, w_valM,
        input  d_icode, d_ifun, d_valC, d_valP, d_halt, d_ins_err,
        input  d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
    );

    modport slave (
        input  f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_halt,
        input  w_dstE, w_dstM, w_valE, w_valM,
        output d_icode, d_ifun, d_valC, d_valP, d_halt, d_ins_err,
        output d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
    );
endinterface

// File: rtl/decode_stage.sv
// Y86-64 style decode stage: D pipeline register, register-ID decode, 15-entry register file
// with same-cycle writeback bypass, and operand selection.
module decode_stage #(
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] RSP   = 4'h4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           stall_d,
    input  logic           bubble_d,
    decode_stage_if.slave  dif
);

    logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
    logic [63:0] valc_q, valp_q;
    logic        halt_q;

    logic [63:0] rf_q [15];

    logic [3:0]  srca, srcb, dste, dstm;
    logic [63:0] porta, portb;

    always_ff @(posedge clk) begin
        if (!rst_n || (bubble_d && !stall_d)) begin
            icode_q <= 4'h1;
            ifun_q  <= 4'h0;
            ra_q    <= RNONE;
            rb_q    <= RNONE;
            valc_q  <= '0;
            valp_q  <= '0;
            halt_q  <= 1'b0;
        end else if (!stall_d) begin
            icode_q <= dif.f_icode;
            ifun_q  <= dif.f_ifun;
            ra_q    <= dif.f_rA;
            rb_q    <= dif.f_rB;
            valc_q  <= dif.f_valC;
            valp_q  <= dif.f_valP;
            halt_q  <= dif.f_halt;
        end
    end

    // valM beats valE when both writeback ports name the same register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 15; i++) begin
            if (!rst_n) begin
                rf_q[i] <= '0;
            end else if (dif.w_dstM != RNONE && dif.w_dstM == 4'(i)) begin
                rf_q[i] <= dif.w_valM;
            end else if (dif.w_dstE != RNONE && dif.w_dstE == 4'(i)) begin
                rf_q[i] <= dif.w_valE;
            end
        end
    end

    always_comb begin
        srca = RNONE;
        srcb = RNONE;
        dste = RNONE;
        dstm = RNONE;
        case (icode_q)
            4'h2: begin srca = ra_q; dste = rb_q; end
            4'h3: dste = rb_q;
            4'h4: begin srca = ra_q; srcb = rb_q; end
            4'h5: begin srcb = rb_q; dstm = ra_q; end
            4'h6: begin srca = ra_q; srcb = rb_q; dste = rb_q; end
            4'h8: begin srcb = RSP; dste = RSP; end
            4'h9: begin srca = RSP; srcb = RSP; dste = RSP; end
            4'hA: begin srca = ra_q; srcb = RSP; dste = RSP; end
            4'hB: begin srca = RSP; srcb = RSP; dste = RSP; dstm = ra_q; end
            default: ;
        endcase
    end

    // Bypass the value being written this edge so decode never sees a stale register.
    always_comb begin
        porta = '0;
        if (srca != RNONE) begin
            if (srca == dif.w_dstM)      porta = dif.w_valM;
            else if (srca == dif.w_dstE) porta = dif.w_valE;
            else                         porta = rf_q[srca];
        end
    end

    always_comb begin
        portb = '0;
        if (srcb != RNONE) begin
            if (srcb == dif.w_dstM)      portb = dif.w_valM;
            else if (srcb == dif.w_dstE) portb = dif.w_valE;
            else                         portb = rf_q[srcb];
        end
    end

    assign dif.d_icode   = icode_q;
    assign dif.d_ifun    = ifun_q;
    assign dif.d_valC    = valc_q;
    assign dif.d_valP    = valp_q;
    assign dif.d_halt    = halt_q;
    assign dif.d_ins_err = (icode_q > 4'hB);
    assign dif.d_srcA    = srca;
    assign dif.d_srcB    = srcb;
    assign dif.d_dstE    = dste;
    assign dif.d_dstM    = dstm;
    // JXX and CALL carry the return/fall-through address in valA.
    assign dif.d_valA    = (icode_q == 4'h7 || icode_q == 4'h8) ? valp_q : porta;
    assign dif.d_valB    = portb;

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven check of decode_stage plus hand sequences for bypass and mid-stream reset.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    logic stall_d;
    logic bubble_d;

    decode_stage_if dif ();

    decode_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall_d  (stall_d),
        .bubble_d (bubble_d),
        .dif      (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, bb;
        logic [3:0]  ic, ifn, ra, rb;
        logic [63:0] vc, vp;
        logic        h;
        logic [3:0]  wde;
        logic [63:0] wve;
        logic [3:0]  wdm;
        logic [63:0] wvm;
        logic [3:0]  e_ic, e_ifn;
        logic [63:0] e_vc, e_vp;
        logic        e_h, e_err;
        logic [3:0]  e_sa, e_sb, e_de, e_dm;
        logic [63:0] e_va, e_vb;
    } vec_t;

    vec_t vecs [19];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_f(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                           input logic h);
        dif.f_icode = ic;
        dif.f_ifun  = ifn;
        dif.f_rA    = ra;
        dif.f_rB    = rb;
        dif.f_valC  = vc;
        dif.f_valP  = vp;
        dif.f_halt  = h;
    endtask

    task automatic drive_w(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm,
                           input logic [63:0] vm);
        dif.w_dstE = de;
        dif.w_valE = ve;
        dif.w_dstM = dm;
        dif.w_valM = vm;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, ".icode"}, 64'(dif.d_icode), 64'(v.e_ic));
        chk({tag, ".ifun"}, 64'(dif.d_ifun), 64'(v.e_ifn));
        chk({tag, ".valC"}, dif.d_valC, v.e_vc);
        chk({tag, ".valP"}, dif.d_valP, v.e_vp);
        chk({tag, ".halt"}, 64'(dif.d_halt), 64'(v.e_h));
        chk({tag, ".ins_err"}, 64'(dif.d_ins_err), 64'(v.e_err));
        chk({tag, ".srcA"}, 64'(dif.d_srcA), 64'(v.e_sa));
        chk({tag, ".srcB"}, 64'(dif.d_srcB), 64'(v.e_sb));
        chk({tag, ".dstE"}, 64'(dif.d_dstE), 64'(v.e_de));
        chk({tag, ".dstM"}, 64'(dif.d_dstM), 64'(v.e_dm));
        chk({tag, ".valA"}, dif.d_valA, v.e_va);
        chk({tag, ".valB"}, dif.d_valB, v.e_vb);
    endtask

    initial begin
        vec_t nop;
        nop = '{1'b0, 1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0,
                4'hF, 64'h0, 4'hF, 64'h0,
                4'h1, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0};

        // Rows: stall, bubble, f_*, w_* | expected d_* after the edge.
        vecs[0]  = '{1'b0, 1'b0, 4'h3, 4'h0, 4'hF, 4'h2, 64'hAA, 64'hC, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'h3, 4'h0, 64'hAA, 64'hC, 1'b0, 1'b0, 4'hF, 4'hF, 4'h2, 4'hF,
                     64'h0, 64'h0};
        vecs[1]  = nop;
        vecs[1].wde = 4'h2;
        vecs[1].wve = 64'hAA;
        vecs[2]  = '{1'b0, 1'b0, 4'h6, 4'h0, 4'h2, 4'h4, 64'h0, 64'h2, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'h6, 4'h0, 64'h0, 64'h2, 1'b0, 1'b0, 4'h2, 4'h4, 4'h4, 4'hF,
                     64'hAA, 64'h0};
        vecs[3]  = nop;
        vecs[3].wde = 4'h4;
        vecs[3].wve = 64'h100;
        vecs[4]  = '{1'b0, 1'b0, 4'h7, 4'h1, 4'hF, 4'hF, 64'h50, 64'h27, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'h7, 4'h1, 64'h50, 64'h27, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF,
                     64'h27, 64'h0};
        vecs[5]  = '{1'b0, 1'b0, 4'hB, 4'h0, 4'h3, 4'hF, 64'h0, 64'h40, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'hB, 4'h0, 64'h0, 64'h40, 1'b0, 1'b0, 4'h4, 4'h4, 4'h4, 4'h3,
                     64'h100, 64'h100};
        vecs[6]  = '{1'b0, 1'b0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h33, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'h8, 4'h0, 64'h200, 64'h33, 1'b0, 1'b0, 4'hF, 4'h4, 4'h4, 4'hF,
                     64'h33, 64'h100};
        vecs[7]  = '{1'b0, 1'b0, 4'h5, 4'h0, 4'h7, 4'h4, 64'h8, 64'h4A, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'h5, 4'h0, 64'h8, 64'h4A, 1'b0, 1'b0, 4'hF, 4'h4, 4'hF, 4'h7,
                     64'h0, 64'h100};
        vecs[8]  = '{1'b0, 1'b0, 4'h3, 4'h0, 4'hF, 4'h6, 64'h5, 64'h54, 1'b0,
                     4'h6, 64'h1, 4'h6, 64'h2,
                     4'h3, 4'h0, 64'h5, 64'h54, 1'b0, 1'b0, 4'hF, 4'hF, 4'h6, 4'hF,
                     64'h0, 64'h0};
        vecs[9]  = '{1'b0, 1'b0, 4'h4, 4'h0, 4'h6, 4'h4, 64'h10, 64'h5E, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'h4, 4'h0, 64'h10, 64'h5E, 1'b0, 1'b0, 4'h6, 4'h4, 4'hF, 4'hF,
                     64'h2, 64'h100};
        vecs[10] = '{1'b0, 1'b0, 4'hC, 4'h3, 4'h1, 4'h2, 64'hDEAD, 64'h60, 1'b1,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'hC, 4'h3, 64'hDEAD, 64'h60, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF,
                     64'h0, 64'h0};
        // Two stall cycles, then stall+bubble: all hold vecs[10].
        vecs[11] = vecs[10];
        vecs[11].st = 1'b1; vecs[11].ic = 4'h2; vecs[11].ra = 4'h1; vecs[11].vc = 64'h77;
        vecs[12] = vecs[10];
        vecs[12].st = 1'b1; vecs[12].ic = 4'h6; vecs[12].vp = 64'h99; vecs[12].h = 1'b0;
        vecs[13] = vecs[10];
        vecs[13].st = 1'b1; vecs[13].bb = 1'b1; vecs[13].ic = 4'h6; vecs[13].vc = 64'h88;
        vecs[14] = nop;
        vecs[14].bb = 1'b1; vecs[14].ic = 4'h6; vecs[14].vc = 64'h88; vecs[14].h = 1'b1;
        vecs[15] = '{1'b0, 1'b0, 4'hA, 4'h0, 4'h4, 4'hF, 64'h0, 64'h66, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'hA, 4'h0, 64'h0, 64'h66, 1'b0, 1'b0, 4'h4, 4'h4, 4'h4, 4'hF,
                     64'h100, 64'h100};
        vecs[16] = '{1'b0, 1'b0, 4'h2, 4'h5, 4'h6, 4'h3, 64'h0, 64'h68, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'h2, 4'h5, 64'h0, 64'h68, 1'b0, 1'b0, 4'h6, 4'hF, 4'h3, 4'hF,
                     64'h2, 64'h0};
        vecs[17] = '{1'b0, 1'b0, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h6A, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'h9, 4'h0, 64'h0, 64'h6A, 1'b0, 1'b0, 4'h4, 4'h4, 4'h4, 4'hF,
                     64'h100, 64'h100};
        vecs[18] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h2, 4'h2, 64'h1, 64'h6C, 1'b0,
                     4'hF, 64'h0, 4'hF, 64'h0,
                     4'hF, 4'h0, 64'h1, 64'h6C, 1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF,
                     64'h0, 64'h0};

        // Reset with a pending writeback and a live instruction; both must be discarded.
        rst_n    = 1'b0;
        stall_d  = 1'b0;
        bubble_d = 1'b0;
        drive_f(4'h6, 4'h0, 4'h2, 4'h2, 64'h5, 64'h6, 1'b1);
        drive_w(4'h2, 64'h11, 4'hF, 64'h0);
        step();
        step();
        check_all("reset", nop);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            stall_d  = vecs[i].st;
            bubble_d = vecs[i].bb;
            drive_f(vecs[i].ic, vecs[i].ifn, vecs[i].ra, vecs[i].rb, vecs[i].vc, vecs[i].vp,
                    vecs[i].h);
            drive_w(vecs[i].wde, vecs[i].wve, vecs[i].wdm, vecs[i].wvm);
            step();
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Same-cycle bypass on both read ports while D holds OPQ rA=3 rB=5.
        stall_d  = 1'b0;
        bubble_d = 1'b0;
        drive_f(4'h6, 4'h0, 4'h3, 4'h5, 64'h0, 64'h70, 1'b0);
        drive_w(4'hF, 64'h0, 4'hF, 64'h0);
        step();
        chk("byp.pre_valA", dif.d_valA, 64'h0);
        chk("byp.pre_valB", dif.d_valB, 64'h0);
        drive_w(4'h5, 64'h77, 4'h3, 64'h55);
        #1;
        chk("byp.valA", dif.d_valA, 64'h55);
        chk("byp.valB", dif.d_valB, 64'h77);
        drive_w(4'h3, 64'h99, 4'h3, 64'h55);
        #1;
        chk("byp.m_over_e", dif.d_valA, 64'h55);
        step();
        drive_w(4'hF, 64'h0, 4'hF, 64'h0);
        #1;
        chk("byp.stored_valA", dif.d_valA, 64'h55);
        chk("byp.stored_valB", dif.d_valB, 64'h0);

        // Mid-stream reset: POPQ pending with writes to RSP and r3 on the reset edge.
        drive_f(4'hB, 4'h0, 4'h3, 4'hF, 64'h0, 64'h72, 1'b0);
        drive_w(4'h4, 64'h999, 4'h3, 64'h123);
        rst_n = 1'b0;
        step();
        chk("mrst.icode", 64'(dif.d_icode), 64'h1);
        chk("mrst.srcA", 64'(dif.d_srcA), 64'hF);
        rst_n = 1'b1;
        drive_w(4'hF, 64'h0, 4'hF, 64'h0);
        step();
        chk("mrst.pop_icode", 64'(dif.d_icode), 64'hB);
        chk("mrst.pop_valA", dif.d_valA, 64'h0);
        chk("mrst.pop_dstM", 64'(dif.d_dstM), 64'h3);
        drive_f(4'h6, 4'h0, 4'h3, 4'h6, 64'h0, 64'h74, 1'b0);
        step();
        chk("mrst.r3", dif.d_valA, 64'h0);
        chk("mrst.r6", dif.d_valB, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
